// File: rtl/mem_arbiter.sv
// Two-way arbiter sharing one main-memory beat port between icache and dcache line transfers.
// Define MEM_ARB_RR_EN for round-robin tie breaking; otherwise dcache has fixed priority.
module mem_arbiter #(
  parameter int AW    = 12,
  parameter int DW    = 128,
  parameter int BEATS = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ic_req_valid,
  output logic          ic_req_ready,
  input  logic [AW-1:0] ic_req_addr,
  output logic          ic_rsp_valid,
  output logic [DW-1:0] ic_rsp_data,
  input  logic          dc_req_valid,
  output logic          dc_req_ready,
  input  logic          dc_req_rtype,
  input  logic [AW-1:0] dc_req_addr,
  input  logic [DW-1:0] dc_wdata,
  output logic          dc_wdata_ready,
  output logic          dc_rsp_valid,
  output logic [DW-1:0] dc_rsp_data,
  output logic          dc_wr_done,
  output logic          mem_req_valid,
  input  logic          mem_req_ready,
  output logic          mem_req_we,
  output logic [AW-1:0] mem_req_addr,
  output logic [DW-1:0] mem_req_wdata,
  input  logic          mem_rsp_valid,
  input  logic [DW-1:0] mem_rsp_data,
  output logic [1:0]    state_dbg
);
  localparam int LB = $clog2(BEATS);
  localparam int CW = LB + 1;
  localparam logic [CW-1:0] BEATS_C  = CW'(BEATS);
  localparam logic [CW-1:0] LAST_C   = CW'(BEATS - 1);
  localparam logic [AW-1:0] LOW_MASK = AW'(BEATS - 1);
  localparam logic OWN_IC = 1'b0;
  localparam logic OWN_DC = 1'b1;
  localparam logic DMEM_WRITE = 1'b1;

  typedef enum logic [1:0] {ARB_IDLE = 2'd0, ARB_RD = 2'd1, ARB_WR = 2'd2} arb_state_t;

  arb_state_t    state;
  logic          owner;
  logic [AW-1:0] line_addr;
  logic [CW-1:0] iss_cnt;
  logic [CW-1:0] rsp_cnt;
  logic          grant_ic;
  logic          grant_dc;
  logic          mem_fire;

  // Every handshake is valid/ready: a transfer happens in the cycle both are high,
  // and ready is only ever raised for the single winner while the arbiter is idle.
`ifdef MEM_ARB_RR_EN
  logic last_grant;
`endif

  always_comb begin
    grant_ic = 1'b0;
    grant_dc = 1'b0;
    if (state == ARB_IDLE && !rst) begin
`ifdef MEM_ARB_RR_EN
      if (ic_req_valid && dc_req_valid) begin
        grant_ic = (last_grant == OWN_DC);
        grant_dc = (last_grant == OWN_IC);
      end else begin
        grant_ic = ic_req_valid;
        grant_dc = dc_req_valid;
      end
`else
      grant_dc = dc_req_valid;
      grant_ic = ic_req_valid && !dc_req_valid;
`endif
    end
  end

  assign ic_req_ready   = grant_ic;
  assign dc_req_ready   = grant_dc;
  assign mem_req_valid  = ((state == ARB_RD) && (iss_cnt < BEATS_C)) || (state == ARB_WR);
  assign mem_req_we     = (state == ARB_WR);
  assign mem_req_addr   = line_addr | AW'(iss_cnt[LB-1:0]);
  assign mem_req_wdata  = dc_wdata;
  assign mem_fire       = mem_req_valid && mem_req_ready;
  assign dc_wdata_ready = (state == ARB_WR) && mem_req_ready;
  assign dc_wr_done     = dc_wdata_ready && (iss_cnt == LAST_C);
  // Read data is shared; only the owner's valid is raised.
  assign ic_rsp_valid   = (state == ARB_RD) && (owner == OWN_IC) && mem_rsp_valid;
  assign dc_rsp_valid   = (state == ARB_RD) && (owner == OWN_DC) && mem_rsp_valid;
  assign ic_rsp_data    = mem_rsp_data;
  assign dc_rsp_data    = mem_rsp_data;
  assign state_dbg      = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ARB_IDLE;
      owner     <= OWN_DC;
      line_addr <= '0;
      iss_cnt   <= '0;
      rsp_cnt   <= '0;
`ifdef MEM_ARB_RR_EN
      last_grant <= OWN_DC;
`endif
    end else begin
      case (state)
        ARB_IDLE: begin
          iss_cnt <= '0;
          rsp_cnt <= '0;
          if (grant_dc) begin
            owner     <= OWN_DC;
            line_addr <= dc_req_addr & ~LOW_MASK;
            state     <= (dc_req_rtype == DMEM_WRITE) ? ARB_WR : ARB_RD;
          end else if (grant_ic) begin
            owner     <= OWN_IC;
            line_addr <= ic_req_addr & ~LOW_MASK;
            state     <= ARB_RD;
          end
`ifdef MEM_ARB_RR_EN
          if (grant_dc || grant_ic) last_grant <= grant_dc ? OWN_DC : OWN_IC;
`endif
        end
        ARB_RD: begin
          if (mem_fire) iss_cnt <= iss_cnt + CW'(1);
          if (mem_rsp_valid) begin
            rsp_cnt <= rsp_cnt + CW'(1);
            if (rsp_cnt == LAST_C) state <= ARB_IDLE;
          end
        end
        ARB_WR: begin
          if (mem_fire) begin
            iss_cnt <= iss_cnt + CW'(1);
            if (iss_cnt == LAST_C) state <= ARB_IDLE;
          end
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a latency-configurable memory model and a dcache write-beat source.
module tb_mem_arbiter;
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         ic_req_valid = 1'b0;
  logic         ic_req_ready;
  logic [11:0]  ic_req_addr = '0;
  logic         ic_rsp_valid;
  logic [127:0] ic_rsp_data;
  logic         dc_req_valid = 1'b0;
  logic         dc_req_ready;
  logic         dc_req_rtype = 1'b0;
  logic [11:0]  dc_req_addr = '0;
  logic [127:0] dc_wdata;
  logic         dc_wdata_ready;
  logic         dc_rsp_valid;
  logic [127:0] dc_rsp_data;
  logic         dc_wr_done;
  logic         mem_req_valid;
  logic         mem_req_ready = 1'b1;
  logic         mem_req_we;
  logic [11:0]  mem_req_addr;
  logic [127:0] mem_req_wdata;
  logic         mem_rsp_valid;
  logic [127:0] mem_rsp_data;
  logic [1:0]   state_dbg;

  mem_arbiter dut (
    .clk(clk), .rst(rst),
    .ic_req_valid(ic_req_valid), .ic_req_ready(ic_req_ready), .ic_req_addr(ic_req_addr),
    .ic_rsp_valid(ic_rsp_valid), .ic_rsp_data(ic_rsp_data),
    .dc_req_valid(dc_req_valid), .dc_req_ready(dc_req_ready), .dc_req_rtype(dc_req_rtype),
    .dc_req_addr(dc_req_addr), .dc_wdata(dc_wdata), .dc_wdata_ready(dc_wdata_ready),
    .dc_rsp_valid(dc_rsp_valid), .dc_rsp_data(dc_rsp_data), .dc_wr_done(dc_wr_done),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_we(mem_req_we),
    .mem_req_addr(mem_req_addr), .mem_req_wdata(mem_req_wdata),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
    .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // scoreboard counters and check
  int vec_cnt = 0;
  int err_cnt = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] mem_data(input logic [11:0] a);
    return {8{a, 4'hA}};
  endfunction

  function automatic logic [127:0] wr_data(input int idx);
    logic [11:0] i;
    i = 12'(idx);
    return {8{4'h5, i}};
  endfunction

  function automatic logic [31:0] pk_iss(input int rel, input logic we, input logic [11:0] a);
    return {8'(rel), 7'd0, we, 4'd0, a};
  endfunction

  // dcache write-beat source: advances one beat per consumed beat
  int wb_idx = 0;
  always @(posedge clk) if (dc_wdata_ready) wb_idx <= wb_idx + 1;
  assign dc_wdata = wr_data(wb_idx);

  // memory model: in-order read returns after lat cycles, not affected by arbiter reset
  int lat = 1;
  logic [2:0]  pv = '0;
  logic [11:0] pa [3];
  logic        spur = 1'b0;
  always @(posedge clk) begin
    pv    <= {pv[1:0], mem_req_valid & mem_req_ready & ~mem_req_we};
    pa[0] <= mem_req_addr;
    pa[1] <= pa[0];
    pa[2] <= pa[1];
  end
  assign mem_rsp_valid = pv[lat-1] | spur;
  assign mem_rsp_data  = mem_data(pa[lat-1]);

  // driver for mem_req_ready and spurious responses, relative to the last grant
  int cyc = 0;
  int g_cyc = 0;
  bit rdy_tog = 1'b0;
  int spur_rel = -1;
  bit spur_now = 1'b0;
  initial forever begin
    @(posedge clk); #1;
    if (rdy_tog) mem_req_ready = (((cyc - g_cyc + 1) % 2) == 1);
    else mem_req_ready = 1'b1;
    spur = spur_now || ((cyc - g_cyc + 1) == spur_rel);
  end

  // monitor: records observed events with cycle offsets from the grant
  logic [0:0]   grant_q [$];
  logic [31:0]  iss_q [$];
  logic [127:0] wd_q [$];
  logic [8:0]   rtag_q [$];
  logic [127:0] rdat_q [$];
  int done_cnt = 0, done_rel = 0, wdr_err = 0, icr_cnt = 0, both_err = 0;
  initial forever begin
    @(negedge clk);
    cyc = cyc + 1;
    if (ic_req_ready | dc_req_ready) begin
      g_cyc = cyc;
      grant_q.push_back(dc_req_ready);
      if (ic_req_ready) icr_cnt++;
    end
    if (ic_req_ready & dc_req_ready) both_err++;
    if (mem_req_valid & mem_req_ready) begin
      iss_q.push_back(pk_iss(cyc - g_cyc, mem_req_we, mem_req_addr));
      if (mem_req_we) wd_q.push_back(mem_req_wdata);
    end
    if (dc_wdata_ready !== (mem_req_valid & mem_req_ready & mem_req_we)) wdr_err++;
    if (ic_rsp_valid) begin
      rtag_q.push_back({1'b0, 8'(cyc - g_cyc)});
      rdat_q.push_back(ic_rsp_data);
    end
    if (dc_rsp_valid) begin
      rtag_q.push_back({1'b1, 8'(cyc - g_cyc)});
      rdat_q.push_back(dc_rsp_data);
    end
    if (ic_rsp_valid & dc_rsp_valid) both_err++;
    if (dc_wr_done) begin
      done_cnt++;
      done_rel = cyc - g_cyc;
    end
  end

  task automatic clear_mon();
    grant_q.delete(); iss_q.delete(); wd_q.delete(); rtag_q.delete(); rdat_q.delete();
    done_cnt = 0; wdr_err = 0; icr_cnt = 0; both_err = 0;
  endtask

  task automatic request(input bit is_dc, input bit we, input logic [11:0] addr, input string tag);
    int n = 0;
    int sz = grant_q.size();
    @(posedge clk); #1;
    if (is_dc) begin
      dc_req_valid = 1'b1; dc_req_rtype = we; dc_req_addr = addr;
    end else begin
      ic_req_valid = 1'b1; ic_req_addr = addr;
    end
    do begin
      @(negedge clk); #1; n++;
    end while (grant_q.size() == sz && n < 20);
    if (grant_q.size() == sz) check({tag, " grant timeout"}, 128'(grant_q.size()), 128'(sz + 1));
    @(posedge clk); #1;
    ic_req_valid = 1'b0;
    dc_req_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag, output int rel);
    int n = 0;
    do begin
      @(negedge clk); #1; n++;
    end while (state_dbg != 2'd0 && n < 50);
    if (state_dbg != 2'd0) check({tag, " idle timeout"}, 128'(state_dbg), 128'(0));
    rel = cyc - g_cyc;
  endtask

  task automatic check_reads(input string tag, input logic own, input logic [11:0] base, input int first_rel);
    check({tag, " rsp count"}, 128'(rtag_q.size()), 128'(4));
    for (int k = 0; k < 4; k++) begin
      check({tag, " rsp tag"}, 128'(k < rtag_q.size() ? rtag_q[k] : 9'bx), 128'({own, 8'(first_rel + k)}));
      check({tag, " rsp data"}, k < rdat_q.size() ? rdat_q[k] : 128'bx, mem_data(base + 12'(k)));
    end
  endtask

  task automatic check_issues(input string tag, input logic we, input logic [11:0] base, input int step);
    check({tag, " issue count"}, 128'(iss_q.size()), 128'(4));
    for (int k = 0; k < 4; k++)
      check({tag, " issue"}, 128'(k < iss_q.size() ? iss_q[k] : 32'bx), 128'(pk_iss(1 + k * step, we, base + 12'(k))));
  endtask

  initial begin
    int rel;
    int w0;
    logic [0:0] exp_g [3];
`ifdef MEM_ARB_RR_EN
    exp_g[0] = 1'b0; exp_g[1] = 1'b1; exp_g[2] = 1'b0;
`else
    exp_g[0] = 1'b1; exp_g[1] = 1'b1; exp_g[2] = 1'b1;
`endif

    // reset state with both requesters pushing
    ic_req_valid = 1'b1;
    dc_req_valid = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    check("rst ic_req_ready", 128'(ic_req_ready), 128'(0));
    check("rst dc_req_ready", 128'(dc_req_ready), 128'(0));
    check("rst mem_req_valid", 128'(mem_req_valid), 128'(0));
    check("rst dc_wdata_ready", 128'(dc_wdata_ready), 128'(0));
    check("rst dc_wr_done", 128'(dc_wr_done), 128'(0));
    check("rst state", 128'(state_dbg), 128'(0));
    ic_req_valid = 1'b0;
    dc_req_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (2) @(posedge clk);

    // single icache read, 1-cycle memory
    clear_mon();
    request(1'b0, 1'b0, 12'h12C, "ic_rd");
    wait_idle("ic_rd", rel);
    check("ic_rd grants", 128'(grant_q.size()), 128'(1));
    check("ic_rd ic_req_ready pulses", 128'(icr_cnt), 128'(1));
    check_issues("ic_rd", 1'b0, 12'h12C, 1);
    check_reads("ic_rd", 1'b0, 12'h12C, 2);
    check("ic_rd idle cycle", 128'(rel), 128'(6));
    check("ic_rd exclusive", 128'(both_err), 128'(0));

    // spurious response while idle
    clear_mon();
    @(posedge clk); #2; spur_now = 1'b1;
    @(posedge clk); #2; spur_now = 1'b0;
    @(negedge clk); #1;
    check("idle spur rsp", 128'(rtag_q.size()), 128'(0));
    check("idle spur state", 128'(state_dbg), 128'(0));

    // dcache write-back with toggling ready and a spurious response mid-write
    clear_mon();
    rdy_tog = 1'b1;
    spur_rel = 4;
    w0 = wb_idx;
    request(1'b1, 1'b1, 12'h040, "dc_wr");
    wait_idle("dc_wr", rel);
    rdy_tog = 1'b0;
    spur_rel = -1;
    check_issues("dc_wr", 1'b1, 12'h040, 2);
    for (int k = 0; k < 4; k++)
      check("dc_wr wdata", k < wd_q.size() ? wd_q[k] : 128'bx, wr_data(w0 + k));
    check("dc_wr done count", 128'(done_cnt), 128'(1));
    check("dc_wr done cycle", 128'(done_rel), 128'(7));
    check("dc_wr idle cycle", 128'(rel), 128'(8));
    check("dc_wr wdata_ready align", 128'(wdr_err), 128'(0));
    check("dc_wr no rsp", 128'(rtag_q.size()), 128'(0));

    // dcache read, unaligned request address, 3-cycle memory
    repeat (3) @(posedge clk);
    lat = 3;
    clear_mon();
    request(1'b1, 1'b0, 12'h0B6, "dc_rd3");
    wait_idle("dc_rd3", rel);
    check_issues("dc_rd3", 1'b0, 12'h0B4, 1);
    check_reads("dc_rd3", 1'b1, 12'h0B4, 4);
    check("dc_rd3 idle cycle", 128'(rel), 128'(8));

    // reset during the second beat of a dcache read
    repeat (3) @(posedge clk);
    clear_mon();
    request(1'b1, 1'b0, 12'h080, "rst_rd");
    @(posedge clk); #2;
    rst = 1'b1;
    @(negedge clk); #1;
    check("rst_mid mem_req_valid", 128'(mem_req_valid), 128'(0));
    check("rst_mid dc_rsp_valid", 128'(dc_rsp_valid), 128'(0));
    check("rst_mid state", 128'(state_dbg), 128'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    check("rst_mid late beats dropped", 128'(rtag_q.size()), 128'(0));
    check("rst_mid issued beats", 128'(iss_q.size()), 128'(1));
    clear_mon();
    request(1'b0, 1'b0, 12'h200, "ic_after_rst");
    wait_idle("ic_after_rst", rel);
    check_reads("ic_after_rst", 1'b0, 12'h200, 4);
    check("ic_after_rst idle cycle", 128'(rel), 128'(8));

    // simultaneous requesters, three back-to-back grants from a fresh reset
    lat = 1;
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    clear_mon();
    begin
      int n = 0;
      @(posedge clk); #1;
      ic_req_valid = 1'b1; ic_req_addr = 12'h300;
      dc_req_valid = 1'b1; dc_req_rtype = 1'b0; dc_req_addr = 12'h3C0;
      while (grant_q.size() < 3 && n < 100) begin
        @(negedge clk); #1; n++;
      end
      @(posedge clk); #1;
      ic_req_valid = 1'b0;
      dc_req_valid = 1'b0;
    end
    wait_idle("tie", rel);
    check("tie grant count", 128'(grant_q.size()), 128'(3));
    for (int k = 0; k < 3; k++)
      check("tie grant owner", 128'(k < grant_q.size() ? grant_q[k] : 1'bx), 128'(exp_g[k]));
    check("tie exclusive", 128'(both_err), 128'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares the single 128-bit main-memory port between the instruction cache and the data cache. Accepts whole-line requests (icache line fill; dcache line fill or dirty-line write-back) and sequences each as `BEATS` consecutive 128-bit memory beats. Routes read beats back to the owning cache. Sits between `icache`/`dcache` miss/evict logic and the main-memory model/controller.

## Interface
Parameters:
- `AW`, default `MEM_ADDR_BUS` (12): memory beat-address width.
- `DW`, default `MEM_DATA_BUS` (128): beat data width.
- `BEATS`, default `MEM_TRANSFERS_PER_CL` (4): beats per cache line; must be a power of 2, ≥2.

Ports:
- `clk`  in  1  clock. One clock domain.
- `rst`  in  1  reset, asynchronous, active-high.
- `ic_req_valid`  in  1  icache line-read request.
- `ic_req_ready`  out  1  icache request accepted this cycle.
- `ic_req_addr`  in  AW  line beat address; low `log2(BEATS)` bits ignored.
- `ic_rsp_valid`  out  1  icache read beat valid.
- `ic_rsp_data`  out  DW  icache read beat.
- `dc_req_valid`  in  1  dcache line request.
- `dc_req_ready`  out  1  dcache request accepted this cycle.
- `dc_req_rtype`  in  1  `dmem_rtype_t`: `DMEM_READ` fill or `DMEM_WRITE` write-back.
- `dc_req_addr`  in  AW  line beat address; low bits ignored.
- `dc_wdata`  in  DW  write-back beat, indexed by the current beat.
- `dc_wdata_ready`  out  1  current write beat consumed; dcache advances its beat.
- `dc_rsp_valid`  out  1  dcache read beat valid.
- `dc_rsp_data`  out  DW  dcache read beat.
- `dc_wr_done`  out  1  one-cycle pulse when the write-back fully completes.
- `mem_req_valid`  out  1  beat request to memory.
- `mem_req_ready`  in  1  memory accepts the beat.
- `mem_req_we`  out  1  beat is a write.
- `mem_req_addr`  out  AW  beat address.
- `mem_req_wdata`  out  DW  write beat data (equals `dc_wdata`).
- `mem_rsp_valid`  in  1  read beat returned, in order.
- `mem_rsp_data`  in  DW  returned beat.

## Operation
- FSM `arb_state_t`: `ARB_IDLE`, `ARB_RD`, `ARB_WR`. Registers: `owner` (IC/DC), `line_addr`, `iss_cnt`, `rsp_cnt` (log2(BEATS)+1 bits each), `last_grant`.
- `ARB_IDLE`: the arbiter picks a winner among valid requesters. It asserts the winner's `*_req_ready` combinationally and latches owner, address (low bits cleared) and rtype. It goes to `ARB_RD` (IC, or DC read) or `ARB_WR` (DC write). The loser's ready stays 0.
- `ARB_RD`:
  - `mem_req_valid=1` while `iss_cnt<BEATS`.
  - `mem_req_addr={line_addr[AW-1:log2 BEATS], iss_cnt[log2 BEATS-1:0]}`, `mem_req_we=0`.
  - `iss_cnt++` on `mem_req_valid&mem_req_ready`.
  - Each `mem_rsp_valid` is forwarded the same cycle to the owner's `*_rsp_valid/data`, and `rsp_cnt++`.
  - Exit to IDLE when `rsp_cnt` reaches BEATS.
- `ARB_WR`:
  - `mem_req_valid=1`, `mem_req_we=1`, `mem_req_wdata=dc_wdata`.
  - `dc_wdata_ready=mem_req_ready`.
  - `iss_cnt++` per accepted beat.
  - After the last accepted beat: pulse `dc_wr_done`, go to IDLE.
- Responses are never interleaved. A transaction always runs to completion before re-arbitration.
- `mem_rsp_valid` outside `ARB_RD` is dropped. The non-owner's `*_rsp_valid` is always 0.
- `*_rsp_data` outputs are `mem_rsp_data` unconditionally; only the valid lines are gated.

## Timing
- Grant to first `mem_req_valid`: 1 cycle (registered address/state).
- Read, 1-cycle memory, ready always high: beats issued on cycles 1..4, responses forwarded on cycles 2..5, IDLE on cycle 6.
- Write, ready always high: beats on cycles 1..4, `dc_wr_done` on cycle 4, IDLE on cycle 5.
- Minimum one `ARB_IDLE` cycle between transactions.
- A request may be dropped before it is granted. Once granted, the requester is not re-handshaken.
- Reset values: state `ARB_IDLE`, counters 0, `last_grant=DC`. All valid/ready/done outputs are 0 while `rst` is high. Address/wdata outputs are don't-care.
- Reset mid-transaction aborts immediately (asynchronous). Memory beats still in flight after reset release are dropped in IDLE.

## Configuration
- `MEM_ARB_RR_EN` undefined: fixed priority, dcache wins every tie. `last_grant` is unused.
- `MEM_ARB_RR_EN` defined: round-robin. On a tie, the requester not equal to `last_grant` wins, and `last_grant` updates on every grant. After reset, icache wins the first tie.

## Test plan
- Single IC read at addr 0x12C: memory receives 0x12C..0x12F with `we=0`. Four beats D0..D3 appear on `ic_rsp_*` only. `ic_req_ready` pulses once.
- DC write-back at 0x040 with `mem_req_ready` toggling 1,0,1,0…: four beats at 0x040..0x043, each `dc_wdata_ready` coincides with acceptance, one `dc_wr_done` pulse, zero `dc_rsp_valid`.
- Simultaneous IC and DC valid, three back-to-back:
  - Macro off: DC, DC, DC (IC starves while DC stays valid).
  - `MEM_ARB_RR_EN` on: IC, DC, IC.
- Memory with 3-cycle response latency and `mem_req_ready=1`: four issues on consecutive cycles, responses three cycles later in order, IDLE after the 4th response.
- Assert `rst` during beat 2 of a DC read: all valids drop in the same cycle. Late `mem_rsp_valid` beats are ignored. A subsequent IC read completes normally.
- Spurious `mem_rsp_valid` in IDLE and during `ARB_WR`: no `*_rsp_valid` asserted, and counters are unchanged.
